// File: rtl/alu_decode.sv
// RV32I ALU-class decoder with a two-entry (output + skid) ready/valid buffer.
// Build option ALU_DECODE_ILLEGAL_EN: pass unsupported opcodes through flagged o_illegal.
module alu_decode (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [2:0]  o_opsel,
  output logic        o_sub,
  output logic        o_unsigned,
  output logic        o_arith,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  output logic        o_branch,
  output logic        o_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [2:0]  opsel;
    logic        sub;
    logic        uns;
    logic        arith;
    logic        branch;
    logic        illegal;
    logic [31:0] op1;
    logic [31:0] op2;
  } cmd_t;

  cmd_t       dec;
  logic       keep;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_inst;

  cmd_t out_q;
  cmd_t skid_q;
  logic out_valid;
  logic skid_valid;
  logic ready_q;
  logic take;
  logic load;
  logic drain;

  assign opcode      = i_inst[6:0];
  assign funct3      = i_inst[14:12];
  assign unused_inst = ^{i_inst[19:15], i_inst[11:7]};

  always_comb begin
    dec  = '0;
    keep = 1'b0;
    case (opcode)
      OPC_OP: begin
        keep      = 1'b1;
        dec.opsel = funct3;
        dec.sub   = (funct3 == 3'b000) && i_inst[30];
        dec.arith = (funct3 == 3'b101) && i_inst[30];
        dec.uns   = (funct3 == 3'b011);
        dec.op1   = i_rs1_data;
        dec.op2   = i_rs2_data;
      end
      OPC_OP_IMM: begin
        keep      = 1'b1;
        dec.opsel = funct3;
        dec.arith = (funct3 == 3'b101) && i_inst[30];
        dec.uns   = (funct3 == 3'b011);
        dec.op1   = i_rs1_data;
        // shifts take only the 5-bit shamt; everything else sign-extends imm[11:0]
        if (funct3 == 3'b001 || funct3 == 3'b101)
          dec.op2 = {27'b0, i_inst[24:20]};
        else
          dec.op2 = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      OPC_BRANCH: begin
        keep       = 1'b1;
        dec.opsel  = 3'b010;
        dec.uns    = funct3[1];
        dec.branch = 1'b1;
        dec.op1    = i_rs1_data;
        dec.op2    = i_rs2_data;
      end
      default: begin
`ifdef ALU_DECODE_ILLEGAL_EN
        keep        = 1'b1;
        dec.illegal = 1'b1;
`else
        keep        = 1'b0;
`endif
      end
    endcase
  end

  // Unsupported opcodes still handshake in; they are just not stored when disabled.
  assign take  = i_valid && ready_q;
  assign load  = take && keep;
  assign drain = out_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (i_flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (skid_valid) begin
      if (drain) begin
        out_q      <= skid_q;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end
    end else if (!out_valid || drain) begin
      out_valid <= load;
      if (load) out_q <= dec;
    end else if (load) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
      ready_q    <= 1'b0;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = out_valid;
  assign o_opsel    = out_q.opsel;
  assign o_sub      = out_q.sub;
  assign o_unsigned = out_q.uns;
  assign o_arith    = out_q.arith;
  assign o_op1      = out_q.op1;
  assign o_op2      = out_q.op2;
  assign o_branch   = out_q.branch;
  assign o_illegal  = out_q.illegal;

endmodule

// File: doc/alu_decode.md
ALU_DECODE -- requirements
Module: alu_decode

Interface
REQ-001 Parameters: none.
REQ-002 i_clk  input  1  rising-edge clock; the block uses one clock.
REQ-003 i_rst  input  1  reset; synchronous and active-high.
REQ-004 i_valid  input  1  upstream instruction valid.
REQ-005 o_ready  output  1  block can accept an instruction; driven from a register.
REQ-006 i_inst  input  32  RV32I instruction word.
REQ-007 i_rs1_data  input  32  rs1 register value.
REQ-008 i_rs2_data  input  32  rs2 register value.
REQ-009 i_flush  input  1  discard all buffered instructions.
REQ-010 o_valid  output  1  decoded ALU command valid.
REQ-011 i_ready  input  1  downstream ALU stage accepts the command.
REQ-012 o_opsel  output  3  ALU major operation select.
REQ-013 o_sub, o_unsigned, o_arith  output  1 each  ALU modifier controls.
REQ-014 o_op1, o_op2  output  32 each  ALU operands.
REQ-015 o_branch  output  1  command is a conditional branch compare.
REQ-016 o_illegal  output  1  unsupported opcode (see Configuration).

Function
REQ-017 A transfer in occurs on the cycle i_valid && o_ready; a transfer out occurs on the cycle o_valid && i_ready.
REQ-018 Storage is two entries: an output register and a skid register. o_ready SHALL equal "skid register empty", registered.
REQ-019 Latency: an accepted instruction appears on the outputs the next cycle. Sustained throughput is 1 per cycle while i_ready is high.
REQ-020 Accept routing:
  - If the output register is empty or drains this cycle, the instruction loads into the output register.
  - Otherwise it loads into the skid register.
  - When the output register drains and the skid register is full, the skid entry moves to the output register.
  - FIFO order is always preserved.
REQ-021 While o_valid=1 and i_ready=0, all outputs SHALL hold stable.
REQ-022 OP decode (opcode 0110011):
  - opsel = funct3.
  - sub = inst[30] when funct3=000.
  - arith = inst[30] when funct3=101.
  - unsigned = (funct3=011).
  - op1 = rs1, op2 = rs2.
REQ-023 OP-IMM decode (opcode 0010011):
  - Same as OP, except sub=0.
  - op2 = sign-extended inst[31:20].
  - For funct3 001/101, op2 = {27'b0, inst[24:20]}.
REQ-024 BRANCH decode (opcode 1100011):
  - opsel=010, sub=0, arith=0, branch=1.
  - unsigned = funct3[1].
  - op1 = rs1, op2 = rs2.
REQ-025 Every modifier not named for an opcode SHALL be 0. o_branch=0 for all non-branch opcodes.
REQ-026 i_flush clears both entries at the next edge (o_valid=0, o_ready=1). An instruction offered on the flush cycle is dropped. Flush has priority over accept and drain.

Reset
REQ-027 While i_rst=1 at an edge: o_valid=0, o_ready=1, skid register empty, and all data outputs = 0.
REQ-028 Reset asserted mid-operation discards both entries. i_rst has priority over i_flush and over all handshakes.

Configuration
REQ-029 Macro ALU_DECODE_ILLEGAL_EN:
  - Defined: unsupported opcodes are accepted and emitted with o_illegal=1, opsel=000, all modifiers 0, op1=op2=0.
  - Undefined: o_illegal is tied to 0, and unsupported instructions are accepted but silently dropped (never raise o_valid).

Verification
REQ-030 Reset, then 0x002081B3 with rs1=5, rs2=7 -> next cycle o_valid=1, opsel=000, sub=0, op1=5, op2=7.
REQ-031 0x402081B3, then 0x40415093 (rs1=0x80000000) back-to-back with i_ready=1 -> sub=1 on cycle 1; on cycle 2 opsel=101, arith=1, op2=4.
REQ-032 0x0020E463 -> opsel=010, unsigned=1, branch=1, op2=rs2. 0xFFF00093 -> op2=0xFFFFFFFF, opsel=000.
REQ-033 i_ready=0 with 3 valid instructions A, B, C offered:
  - A and B are accepted; o_ready falls after B; C is held.
  - Raise i_ready -> outputs A, B, C in order, with no drop or duplication.
REQ-034 With both entries full, assert i_flush with a new valid instruction -> next cycle o_valid=0 and o_ready=1, and the new instruction never appears. Repeat the sequence with i_rst instead of i_flush -> same result.
REQ-035 Offer opcode 0110111:
  - ALU_DECODE_ILLEGAL_EN defined -> o_valid=1, o_illegal=1.
  - Undefined -> no o_valid, and o_ready stays 1.
